// File: rtl/spi_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_arbiter_pkg
// Brief    : Shared types and constants for the arbitrated SPI master.
// Revision : 1.0 - initial release
// ============================================================================
package spi_master_arbiter_pkg;

    localparam int   SPI_BYTE_W = 8;
    // Mode 0: clock idles low, data sampled on the leading (rising) edge.
    localparam logic SPI_CPOL   = 1'b0;
    localparam logic SPI_CPHA   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Counter width that stays legal when the count range collapses to one value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_arbiter_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_arbiter_shift_engine
// Brief    : SPI clock divider and byte shifter, MSB first. A one-cycle load
//            starts a byte; done pulses in the cycle of the final clock toggle.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_arbiter_shift_engine
    import spi_master_arbiter_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [SPI_BYTE_W-1:0] tx_byte,
    input  logic                  miso,
    output logic                  spi_clk,
    output logic                  mosi,
    output logic                  done,
    output logic [SPI_BYTE_W-1:0] rx_byte
);

    localparam int              DIV_W     = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int              EDGE_W    = $clog2(2 * SPI_BYTE_W);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * SPI_BYTE_W - 1);

    logic                  active_q, active_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [EDGE_W-1:0]     edges_q, edges_d;
    logic                  sclk_q, sclk_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;
    logic [SPI_BYTE_W-1:0] rx_q, rx_d;

    logic toggle;
    logic sample_edge;
    logic shift_edge;

    // Edge classification: leading edge samples, trailing edge shifts.
    always_comb begin
        toggle      = active_q && (div_q == DIV_LAST);
        sample_edge = toggle && ((sclk_q == SPI_CPOL) != SPI_CPHA);
        shift_edge  = toggle && !sample_edge;
        done        = toggle && (edges_q == EDGE_LAST);
    end

    // Next-state for divider, edge counter and shift registers.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        edges_d  = edges_q;
        sclk_d   = sclk_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (load) begin
            active_d = 1'b1;
            div_d    = '0;
            edges_d  = '0;
            sclk_d   = SPI_CPOL;
            tx_d     = tx_byte;
        end else if (active_q) begin
            if (toggle) begin
                div_d   = '0;
                sclk_d  = ~sclk_q;
                edges_d = edges_q + 1'b1;
                if (done) begin
                    active_d = 1'b0;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
            if (sample_edge) begin
                rx_d = {rx_q[SPI_BYTE_W-2:0], miso};
            end
            if (shift_edge) begin
                tx_d = {tx_q[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    // Engine state register; reset parks the SPI clock at its idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            div_q    <= '0;
            edges_q  <= '0;
            sclk_q   <= SPI_CPOL;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            edges_q  <= edges_d;
            sclk_q   <= sclk_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign spi_clk = sclk_q;
    assign mosi    = tx_q[SPI_BYTE_W-1];
    assign rx_byte = rx_q;

endmodule
`default_nettype wire

// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_arbiter
// Brief    : Round-robin arbiter sharing one mode-0 SPI bus among N_REQ
//            requesters; bursts hold cs low until the grantee flags last.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            last,
    input  logic [SPI_BYTE_W*N_REQ-1:0] tx_data,
    output logic [N_REQ-1:0]            grant,
    output logic                        ack,
    output logic [SPI_BYTE_W-1:0]       rx_data,
    output logic                        busy,
    output logic                        spi_clk,
    output logic                        mosi,
    input  logic                        miso,
    output logic                        cs
);

    localparam int               IDX_W    = cnt_width(N_REQ);
    localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(N_REQ - 1);
    localparam int               DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic                  busy_q, busy_d;
    logic                  cs_q, cs_d;
    logic                  last_q, last_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic [DIV_W-1:0]      rel_q, rel_d;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      cand;
    logic [SPI_BYTE_W-1:0] cur_tx;
    logic                  cur_last;
    logic                  cur_req;
    logic                  eng_load;
    logic                  eng_done;
    logic [SPI_BYTE_W-1:0] eng_rx;

    // Round-robin pick: scan from farthest to nearest so the first set bit after rr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_q;
        cand       = rr_q;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_q) + k) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the current owner's byte, last flag and request.
    always_comb begin
        cur_tx   = '0;
        cur_last = 1'b0;
        cur_req  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                cur_tx   = tx_data[SPI_BYTE_W*i +: SPI_BYTE_W];
                cur_last = last[i];
                cur_req  = req[i];
            end
        end
    end

    // Arbiter FSM next-state and bus-control decisions.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        busy_d    = busy_q;
        cs_d      = cs_q;
        last_d    = last_q;
        rx_data_d = rx_data_q;
        rel_d     = rel_q;
        eng_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_LOAD;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                eng_load = 1'b1;
                last_d   = cur_last;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    rx_data_d = eng_rx;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                // Continue the burst only if the owner still wants another byte.
                if (!last_q && cur_req) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_RELEASE;
                    cs_d    = 1'b1;
                    rel_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (rel_q == DIV_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    rr_d    = owner_q;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state register; reset frees the bus from any state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_q      <= RR_INIT;
            busy_q    <= 1'b0;
            cs_q      <= 1'b1;
            last_q    <= 1'b0;
            rx_data_q <= '0;
            rel_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            cs_q      <= cs_d;
            last_q    <= last_d;
            rx_data_q <= rx_data_d;
            rel_q     <= rel_d;
        end
    end

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_grant
            assign grant[i] = busy_q && (owner_q == IDX_W'(i));
        end
    endgenerate

    assign ack     = (state_q == ST_DONE);
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign cs      = cs_q;

    spi_master_arbiter_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .load    (eng_load),
        .tx_byte (cur_tx),
        .miso    (miso),
        .spi_clk (spi_clk),
        .mosi    (mosi),
        .done    (eng_done),
        .rx_byte (eng_rx)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_arbiter
// Brief    : Scoreboard bench for spi_master_arbiter, N_REQ=2, CLK_DIV=2,
//            miso looped back to mosi unless forced low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_arbiter;

    localparam int N_REQ    = 2;
    localparam int CLK_DIV  = 2;
    localparam int BYTE_CYC = 2 + 16 * CLK_DIV;           // req-to-ack and ack-to-ack
    localparam int REARB    = CLK_DIV + 1 + BYTE_CYC;     // ack to next owner's ack

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [N_REQ-1:0]   last = '0;
    logic [8*N_REQ-1:0] tx_data = '0;
    logic               miso_zero = 1'b0;
    logic [N_REQ-1:0]   grant;
    logic               ack;
    logic [7:0]         rx_data;
    logic               busy;
    logic               spi_clk;
    logic               mosi;
    logic               miso;
    logic               cs;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       exp_item;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] mosi_hist = '0;
    int         sclk_edges = 0;

    assign miso = miso_zero ? 1'b0 : mosi;

    always #5 clk = ~clk;

    spi_master_arbiter #(
        .N_REQ   (N_REQ),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .last    (last),
        .tx_data (tx_data),
        .grant   (grant),
        .ack     (ack),
        .rx_data (rx_data),
        .busy    (busy),
        .spi_clk (spi_clk),
        .mosi    (mosi),
        .miso    (miso),
        .cs      (cs)
    );

    // Wait for an ack pulse; cyc=-1 on timeout, cs_high set if cs seen high.
    task automatic wait_ack(input int budget, output int cyc, output logic cs_high);
        cyc     = -1;
        cs_high = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (cs) cs_high = 1'b1;
            if (ack) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (cs !== 1'b1)      begin n_fail++; $display("FAIL reset_cs got=%b exp=1", cs); end
        n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b exp=0", spi_clk); end
        n_checks++; if (mosi !== 1'b0)    begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        n_checks++; if (grant !== 2'b00)  begin n_fail++; $display("FAIL reset_grant got=%b exp=00", grant); end
        n_checks++; if (ack !== 1'b0)     begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        int   cyc;
        int   e0;
        logic hi;
        logic ok;
        tx_data[7:0] = 8'hA5;
        last         = 2'b01;
        sb_q.push_back('{grant: 2'b01, data: 8'hA5});
        e0  = sclk_edges;
        req = 2'b01;
        @(negedge clk);
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant got=%b exp=01", grant); end
        n_checks++; if (cs !== 1'b0)     begin n_fail++; $display("FAIL single_cs_low got=%b exp=0", cs); end
        wait_ack(60, cyc, hi);
        n_checks++; if (cyc + 1 != BYTE_CYC) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", cyc + 1, BYTE_CYC); end
        n_checks++; if (hi !== 1'b0) begin n_fail++; $display("FAIL single_cs_glitch got=%b exp=0", hi); end
        n_checks++; if (sclk_edges - e0 != 16) begin n_fail++; $display("FAIL single_sclk_edges got=%0d exp=16", sclk_edges - e0); end
        n_checks++; if (mosi_hist !== 8'hA5) begin n_fail++; $display("FAIL single_mosi_bits got=%h exp=a5", mosi_hist); end
        req = 2'b00;
        @(negedge clk);
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL single_cs_release got=%b exp=1", cs); end
        wait_idle(CLK_DIV + 3, ok);
        n_checks++; if (!ok || grant !== 2'b00) begin n_fail++; $display("FAIL single_idle got=%b/%b exp=1/00", ok, grant); end
    endtask

    task automatic test_round_robin();
        int   cyc;
        logic hi;
        logic ok;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        tx_data = 16'hC35A;
        last    = 2'b11;
        sb_q.push_back('{grant: 2'b01, data: 8'h5A});
        sb_q.push_back('{grant: 2'b10, data: 8'hC3});
        sb_q.push_back('{grant: 2'b01, data: 8'h3C});
        req = 2'b11;
        wait_ack(60, cyc, hi);
        n_checks++; if (cyc != BYTE_CYC) begin n_fail++; $display("FAIL rr_first_ack got=%0d exp=%0d", cyc, BYTE_CYC); end
        tx_data[7:0] = 8'h3C;              // req0 stays high: a new burst
        wait_ack(100, cyc, hi);
        n_checks++; if (cyc != REARB) begin n_fail++; $display("FAIL rr_second_ack got=%0d exp=%0d", cyc, REARB); end
        req = 2'b01;
        wait_ack(100, cyc, hi);
        n_checks++; if (cyc != REARB) begin n_fail++; $display("FAIL rr_third_ack got=%0d exp=%0d", cyc, REARB); end
        req = 2'b00;
        wait_idle(CLK_DIV + 3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_idle got=%b exp=1", ok); end
    endtask

    task automatic test_burst();
        int   cyc;
        logic hi;
        logic ok;
        tx_data[15:8] = 8'h01;
        last          = 2'b00;
        sb_q.push_back('{grant: 2'b10, data: 8'h01});
        sb_q.push_back('{grant: 2'b10, data: 8'h02});
        sb_q.push_back('{grant: 2'b10, data: 8'h03});
        req = 2'b10;
        wait_ack(60, cyc, hi);
        n_checks++; if (cyc != BYTE_CYC) begin n_fail++; $display("FAIL burst_ack1 got=%0d exp=%0d", cyc, BYTE_CYC); end
        tx_data[15:8] = 8'h02;
        wait_ack(60, cyc, hi);
        n_checks++; if (cyc != BYTE_CYC) begin n_fail++; $display("FAIL burst_ack2 got=%0d exp=%0d", cyc, BYTE_CYC); end
        n_checks++; if (hi !== 1'b0)     begin n_fail++; $display("FAIL burst_cs2 got=%b exp=0", hi); end
        tx_data[15:8] = 8'h03;
        last          = 2'b10;
        wait_ack(60, cyc, hi);
        n_checks++; if (cyc != BYTE_CYC) begin n_fail++; $display("FAIL burst_ack3 got=%0d exp=%0d", cyc, BYTE_CYC); end
        n_checks++; if (hi !== 1'b0)     begin n_fail++; $display("FAIL burst_cs3 got=%b exp=0", hi); end
        req  = 2'b00;
        last = 2'b00;
        @(negedge clk);
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL burst_cs_rise got=%b exp=1", cs); end
        wait_idle(CLK_DIV + 3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_idle got=%b exp=1", ok); end
    endtask

    task automatic test_reset_mid_shift();
        int   cyc;
        logic hi;
        logic ok;
        tx_data[7:0] = 8'hA5;
        last         = 2'b01;
        req          = 2'b01;
        repeat (16) @(negedge clk);        // spi_clk high, fourth bit sampled
        #2 reset = 1'b1;
        #1;
        n_checks++; if (cs !== 1'b1)      begin n_fail++; $display("FAIL rst_mid_cs got=%b exp=1", cs); end
        n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sclk got=%b exp=0", spi_clk); end
        n_checks++; if (grant !== 2'b00)  begin n_fail++; $display("FAIL rst_mid_grant got=%b exp=00", grant); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        req = 2'b00;
        @(negedge clk);
        reset        = 1'b0;
        tx_data[7:0] = 8'h96;
        sb_q.push_back('{grant: 2'b01, data: 8'h96});
        @(negedge clk);
        req = 2'b01;
        wait_ack(60, cyc, hi);
        n_checks++; if (cyc != BYTE_CYC)     begin n_fail++; $display("FAIL rst_mid_ack got=%0d exp=%0d", cyc, BYTE_CYC); end
        n_checks++; if (mosi_hist !== 8'h96) begin n_fail++; $display("FAIL rst_mid_mosi got=%h exp=96", mosi_hist); end
        req = 2'b00;
        wait_idle(CLK_DIV + 3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_idle got=%b exp=1", ok); end
    endtask

    task automatic test_tx_change_miso_low();
        int   cyc;
        logic hi;
        logic ok;
        miso_zero    = 1'b1;
        tx_data[7:0] = 8'hFF;
        last         = 2'b01;
        sb_q.push_back('{grant: 2'b01, data: 8'h00});
        req = 2'b01;
        repeat (10) @(negedge clk);
        tx_data[7:0] = 8'h00;
        wait_ack(60, cyc, hi);
        n_checks++; if (cyc != BYTE_CYC - 10) begin n_fail++; $display("FAIL txchg_ack got=%0d exp=%0d", cyc, BYTE_CYC - 10); end
        n_checks++; if (mosi_hist !== 8'hFF)  begin n_fail++; $display("FAIL txchg_mosi got=%h exp=ff", mosi_hist); end
        req = 2'b00;
        wait_idle(CLK_DIV + 3, ok);
        miso_zero = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL txchg_idle got=%b exp=1", ok); end
    endtask

    task automatic test_req_drop();
        int   cyc;
        logic hi;
        logic ok;
        tx_data[7:0] = 8'h77;
        last         = 2'b00;
        sb_q.push_back('{grant: 2'b01, data: 8'h77});
        req = 2'b01;
        repeat (10) @(negedge clk);
        req = 2'b00;
        wait_ack(60, cyc, hi);
        n_checks++; if (cyc != BYTE_CYC - 10) begin n_fail++; $display("FAIL drop_ack got=%0d exp=%0d", cyc, BYTE_CYC - 10); end
        @(negedge clk);
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL drop_cs got=%b exp=1", cs); end
        wait_idle(CLK_DIV + 3, ok);
        n_checks++; if (!ok || grant !== 2'b00) begin n_fail++; $display("FAIL drop_idle got=%b/%b exp=1/00", ok, grant); end
        repeat (3) @(negedge clk);
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    endtask

    initial begin
        fork
            // Scoreboard pop and bus invariants, sampled on the falling edge.
            forever begin
                @(negedge clk);
                if (!reset) begin
                    n_checks++;
                    if ($countones(grant) > 1) begin n_fail++; $display("FAIL grant_onehot got=%b exp=onehot0", grant); end
                    n_checks++;
                    if (cs === 1'b0 && grant === 2'b00) begin n_fail++; $display("FAIL cs_without_grant got=cs0/%b exp=grant!=0", grant); end
                    if (ack === 1'b1) begin
                        if (sb_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL sb_unexpected_ack got=%h/%b exp=none", rx_data, grant);
                        end else begin
                            exp_item = sb_q.pop_front();
                            n_checks++;
                            if (rx_data !== exp_item.data) begin n_fail++; $display("FAIL sb_rx_data got=%h exp=%h", rx_data, exp_item.data); end
                            n_checks++;
                            if (grant !== exp_item.grant) begin n_fail++; $display("FAIL sb_grant got=%b exp=%b", grant, exp_item.grant); end
                        end
                    end
                end
            end
            forever begin
                @(posedge spi_clk);
                mosi_hist = {mosi_hist[6:0], mosi};
            end
            forever begin
                @(spi_clk);
                sclk_edges++;
            end
        join_none

        test_reset();
        test_single_byte();
        test_round_robin();
        test_burst();
        test_reset_mid_shift();
        test_tx_change_miso_low();
        test_req_drop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
